// File: rtl/gmii2xgmii.sv
// -----------------------------------------------------------------------------
// gmii2xgmii
//
// Packs a GMII receive byte stream into 64-bit XGMII words. The block works
// entirely in the GMII byte clock domain. A finished word is presented for one
// cycle with xgmii_valid high. In every other cycle xgmii_valid is low and
// xgmii_rxd/xgmii_rxc keep the last word.
//
// Framing:
//   - The first byte of a frame (the first preamble byte) is replaced by /S/
//     in lane 0.
//   - Data bytes fill the lanes in order. A byte received with gmii_er is
//     replaced by /E/.
//   - When gmii_dv falls, /T/ goes into the next free lane. The lanes above it
//     are filled with /I/.
//   - Between frames, with IDLE_WORDS = 1, an all-/I/ word is emitted each
//     time eight idle byte times have passed.
//   - After reset, any frame still in progress is dropped until gmii_dv goes
//     low.
//
// Parameters:
//   IDLE_WORDS  1 = emit idle words between frames; 0 = frame words only
//
// Ports:
//   gmii_clk     in   125 MHz GMII byte clock
//   sys_rst      in   synchronous active-high reset
//   gmii_dv      in   GMII data valid (preamble, SFD and frame bytes)
//   gmii_er      in   GMII receive error, only meaningful with gmii_dv
//   gmii_rxd     in   GMII byte
//   xgmii_rxd    out  64-bit XGMII word, lane n = bits [8n+7:8n], lane 0 first
//   xgmii_rxc    out  per-lane control flags, bit n = 1 for a control char
//   xgmii_valid  out  one-cycle strobe qualifying xgmii_rxd/xgmii_rxc
// -----------------------------------------------------------------------------
module gmii2xgmii #(
    parameter int IDLE_WORDS = 1
) (
    input  logic        gmii_clk,
    input  logic        sys_rst,
    input  logic        gmii_dv,
    input  logic        gmii_er,
    input  logic [7:0]  gmii_rxd,
    output logic [63:0] xgmii_rxd,
    output logic [7:0]  xgmii_rxc,
    output logic        xgmii_valid
);

    localparam logic [7:0]  CH_S      = 8'hFB;
    localparam logic [7:0]  CH_T      = 8'hFD;
    localparam logic [7:0]  CH_E      = 8'hFE;
    localparam logic [7:0]  CH_I      = 8'h07;
    localparam logic [63:0] IDLE_WORD = {8{CH_I}};
    localparam logic        IDLE_EN   = (IDLE_WORDS != 0);

    typedef enum logic [1:0] {
        ST_DROP,
        ST_IDLE,
        ST_DATA
    } state_t;

    state_t      state_reg;
    logic [2:0]  lane_reg;
    logic [63:0] acc_data_reg;
    logic [7:0]  acc_ctrl_reg;

    // Incoming byte after error substitution.
    // An errored byte becomes the /E/ control character.
    logic [7:0] in_byte;
    logic       in_ctrl;

    assign in_byte = gmii_er ? CH_E : gmii_rxd;
    assign in_ctrl = gmii_er;

    // Two candidate words are built from the accumulator with the current lane
    // replaced:
    //   store_*  the incoming byte is written into the current lane
    //   term_*   /T/ is placed in the current lane and every higher lane is
    //            filled with /I/
    // This lets lane 7 (or the /T/ lane) be emitted in the same cycle it
    // arrives, without an extra pipeline stage.
    logic [63:0] store_data;
    logic [7:0]  store_ctrl;
    logic [63:0] term_data;
    logic [7:0]  term_ctrl;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            logic hit;
            logic above;

            assign hit   = (lane_reg == 3'(gi));
            assign above = (3'(gi) > lane_reg);

            assign store_data[8*gi +: 8] = hit ? in_byte : acc_data_reg[8*gi +: 8];
            assign store_ctrl[gi]        = hit ? in_ctrl : acc_ctrl_reg[gi];

            assign term_data[8*gi +: 8]  = hit   ? CH_T :
                                           above ? CH_I : acc_data_reg[8*gi +: 8];
            assign term_ctrl[gi]         = (hit || above) ? 1'b1 : acc_ctrl_reg[gi];
        end
    endgenerate

    always_ff @(posedge gmii_clk) begin
        if (sys_rst) begin
            state_reg    <= ST_DROP;
            lane_reg     <= 3'd0;
            acc_data_reg <= IDLE_WORD;
            acc_ctrl_reg <= 8'hFF;
            xgmii_rxd    <= IDLE_WORD;
            xgmii_rxc    <= 8'hFF;
            xgmii_valid  <= 1'b0;
        end else begin
            // The strobe is a single-cycle pulse by default.
            // The data outputs hold their value unless a word is emitted.
            xgmii_valid <= 1'b0;

            case (state_reg)
                ST_DROP: begin
                    // The remainder of a frame cut by reset is discarded.
                    // The line is busy, so no idle time elapses and the lane
                    // counter is held.
                    // The first quiet cycle counts as the first idle byte.
                    if (!gmii_dv) begin
                        state_reg <= ST_IDLE;
                        lane_reg  <= lane_reg + 3'd1;
                        if (IDLE_EN && (lane_reg == 3'd7)) begin
                            xgmii_rxd   <= IDLE_WORD;
                            xgmii_rxc   <= 8'hFF;
                            xgmii_valid <= 1'b1;
                        end
                    end
                end

                ST_IDLE: begin
                    if (gmii_dv) begin
                        // Frame start always lands in lane 0 as /S/.
                        // Any idle bytes already counted are flushed as a
                        // complete idle word.
                        state_reg    <= ST_DATA;
                        lane_reg     <= 3'd1;
                        acc_data_reg <= {IDLE_WORD[63:8], CH_S};
                        acc_ctrl_reg <= 8'hFF;
                        if (IDLE_EN && (lane_reg != 3'd0)) begin
                            xgmii_rxd   <= IDLE_WORD;
                            xgmii_rxc   <= 8'hFF;
                            xgmii_valid <= 1'b1;
                        end
                    end else begin
                        lane_reg <= lane_reg + 3'd1;
                        if (IDLE_EN && (lane_reg == 3'd7)) begin
                            xgmii_rxd   <= IDLE_WORD;
                            xgmii_rxc   <= 8'hFF;
                            xgmii_valid <= 1'b1;
                        end
                    end
                end

                ST_DATA: begin
                    if (gmii_dv) begin
                        if (lane_reg == 3'd7) begin
                            xgmii_rxd    <= store_data;
                            xgmii_rxc    <= store_ctrl;
                            xgmii_valid  <= 1'b1;
                            acc_data_reg <= IDLE_WORD;
                            acc_ctrl_reg <= 8'hFF;
                            lane_reg     <= 3'd0;
                        end else begin
                            acc_data_reg <= store_data;
                            acc_ctrl_reg <= store_ctrl;
                            lane_reg     <= lane_reg + 3'd1;
                        end
                    end else begin
                        // End of frame: emit the /T/ word and restart idle
                        // counting from lane 0.
                        xgmii_rxd    <= term_data;
                        xgmii_rxc    <= term_ctrl;
                        xgmii_valid  <= 1'b1;
                        acc_data_reg <= IDLE_WORD;
                        acc_ctrl_reg <= 8'hFF;
                        lane_reg     <= 3'd0;
                        state_reg    <= ST_IDLE;
                    end
                end

                default: begin
                    state_reg <= ST_DROP;
                    lane_reg  <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gmii2xgmii.sv
// -----------------------------------------------------------------------------
// tb_gmii2xgmii
//
// Drives two instances of gmii2xgmii from the same GMII stimulus:
//   dut1  IDLE_WORDS = 1
//   dut0  IDLE_WORDS = 0
//
// A queue-based reference model predicts, for every cycle:
//   - the valid strobe of each instance
//   - the held output word of each instance
//
// A table of frames is compared against hand-derived words. Directed sequences
// cover:
//   - the idle flush at frame start
//   - reset in the middle of a frame
//   - idle suppression when IDLE_WORDS = 0
//
// Randomized frames follow.
// -----------------------------------------------------------------------------
module tb_gmii2xgmii;

    localparam logic [63:0] IDLE_W = 64'h0707070707070707;
    localparam logic [63:0] SOF_W  = 64'hD5555555555555FB;
    localparam logic [7:0]  CH_S   = 8'hFB;
    localparam logic [7:0]  CH_T   = 8'hFD;
    localparam logic [7:0]  CH_E   = 8'hFE;
    localparam logic [7:0]  CH_I   = 8'h07;

    logic        clk;
    logic        rst;
    logic        dv;
    logic        er;
    logic [7:0]  rxd;
    logic [63:0] x1_d;
    logic [7:0]  x1_c;
    logic        x1_v;
    logic [63:0] x0_d;
    logic [7:0]  x0_c;
    logic        x0_v;

    gmii2xgmii #(.IDLE_WORDS(1)) dut1 (
        .gmii_clk   (clk),
        .sys_rst    (rst),
        .gmii_dv    (dv),
        .gmii_er    (er),
        .gmii_rxd   (rxd),
        .xgmii_rxd  (x1_d),
        .xgmii_rxc  (x1_c),
        .xgmii_valid(x1_v)
    );

    gmii2xgmii #(.IDLE_WORDS(0)) dut0 (
        .gmii_clk   (clk),
        .sys_rst    (rst),
        .gmii_dv    (dv),
        .gmii_er    (er),
        .gmii_rxd   (rxd),
        .xgmii_rxd  (x0_d),
        .xgmii_rxc  (x0_c),
        .xgmii_valid(x0_v)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    // Frame lanes are collected in a queue of {ctrl, byte}.
    // Idle time is counted in bytes since the last word boundary.
    bit          m_drop  = 1'b1;
    bit          m_frame = 1'b0;
    int          m_gap   = 0;
    logic [8:0]  m_q[$];
    logic [63:0] m1_d = IDLE_W;
    logic [7:0]  m1_c = 8'hFF;
    logic [63:0] m0_d = IDLE_W;
    logic [7:0]  m0_c = 8'hFF;

    // Words emitted by dut0 (frame words only), stored as {rxc, rxd}.
    logic [71:0] fw_q[$];

    task automatic pack(output logic [63:0] w, output logic [7:0] c);
        for (int i = 0; i < 8; i++) begin
            w[8*i +: 8] = m_q[i][7:0];
            c[i]        = m_q[i][8];
        end
        m_q.delete();
    endtask

    task automatic model_step(input logic r, input logic v, input logic e,
                              input logic [7:0] b, output logic emit,
                              output logic is_idle, output logic [63:0] w,
                              output logic [7:0] c);
        emit    = 1'b0;
        is_idle = 1'b0;
        w       = IDLE_W;
        c       = 8'hFF;
        if (r) begin
            m_drop  = 1'b1;
            m_frame = 1'b0;
            m_gap   = 0;
            m_q.delete();
        end else if (m_drop) begin
            if (!v) begin
                m_drop = 1'b0;
                m_gap++;
                if (m_gap % 8 == 0) begin
                    emit    = 1'b1;
                    is_idle = 1'b1;
                end
            end
        end else if (!m_frame) begin
            if (v) begin
                m_frame = 1'b1;
                m_q.delete();
                m_q.push_back({1'b1, CH_S});
                if (m_gap % 8 != 0) begin
                    emit    = 1'b1;
                    is_idle = 1'b1;
                end
            end else begin
                m_gap++;
                if (m_gap % 8 == 0) begin
                    emit    = 1'b1;
                    is_idle = 1'b1;
                end
            end
        end else begin
            if (v) begin
                m_q.push_back(e ? {1'b1, CH_E} : {1'b0, b});
                if (m_q.size() == 8) begin
                    pack(w, c);
                    emit = 1'b1;
                end
            end else begin
                m_q.push_back({1'b1, CH_T});
                while (m_q.size() < 8) m_q.push_back({1'b1, CH_I});
                pack(w, c);
                emit    = 1'b1;
                m_frame = 1'b0;
                m_gap   = 0;
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check_word(input string name, input logic av,
                              input logic [63:0] ad, input logic [7:0] ac,
                              input logic ev, input logic [63:0] ed,
                              input logic [7:0] ec);
        total++;
        if ({av, ad, ac} !== {ev, ed, ec}) begin
            bad++;
            $display("FAIL %s: got valid=%0b rxd=%h rxc=%h, want valid=%0b rxd=%h rxc=%h",
                     name, av, ad, ac, ev, ed, ec);
        end
    endtask

    task automatic check_fw(input string name, input logic [71:0] act,
                            input logic [63:0] ed, input logic [7:0] ec);
        total++;
        if (act !== {ec, ed}) begin
            bad++;
            $display("FAIL %s: got rxd=%h rxc=%h, want rxd=%h rxc=%h",
                     name, act[63:0], act[71:64], ed, ec);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // One GMII byte time.
    // The inputs are applied and sampled at the next rising edge. The
    // outputs are then compared against the model 1 ns later.
    task automatic cyc(input logic r, input logic v, input logic e,
                       input logic [7:0] b);
        logic        emit;
        logic        is_idle;
        logic [63:0] w;
        logic [7:0]  c;
        rst = r;
        dv  = v;
        er  = e;
        rxd = b;
        @(posedge clk);
        #1;
        model_step(r, v, e, b, emit, is_idle, w, c);
        if (r) begin
            m1_d = IDLE_W; m1_c = 8'hFF;
            m0_d = IDLE_W; m0_c = 8'hFF;
        end
        if (emit) begin
            m1_d = w; m1_c = c;
        end
        if (emit && !is_idle) begin
            m0_d = w; m0_c = c;
        end
        check_word("cycle_idle1", x1_v, x1_d, x1_c, emit, m1_d, m1_c);
        check_word("cycle_idle0", x0_v, x0_d, x0_c, emit && !is_idle, m0_d, m0_c);
        if (x0_v) fw_q.push_back({x0_c, x0_d});
    endtask

    // Sends 7x 0x55, 0xD5, data bytes 1..ndata, then one quiet cycle.
    // er_pos selects which data byte (0-based) carries gmii_er.
    task automatic send_frame(input int ndata, input int er_pos,
                              input bit check_flush);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 1'b0, (i == 7) ? 8'hD5 : 8'h55);
            if (check_flush && i == 0)
                check_word("idle_flush_at_start", x1_v, x1_d, x1_c, 1'b1, IDLE_W, 8'hFF);
        end
        for (int i = 0; i < ndata; i++)
            cyc(1'b0, 1'b1, (i == er_pos), 8'(i + 1));
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    typedef struct {
        int          ndata;
        int          er_pos;
        int          nwords;
        logic [63:0] w_mid;
        logic [7:0]  c_mid;
        logic [63:0] w_last;
        logic [7:0]  c_last;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int seen;
        int n;
        int nd;
        int rst_at;

        vecs[0] = '{8,  -1, 3, 64'h0807060504030201, 8'h00, 64'h07070707070707FD, 8'hFF};
        vecs[1] = '{10, -1, 3, 64'h0807060504030201, 8'h00, 64'h0707070707FD0A09, 8'hFC};
        vecs[2] = '{8,   2, 3, 64'h0807060504FE0201, 8'h04, 64'h07070707070707FD, 8'hFF};
        vecs[3] = '{0,  -1, 2, 64'h07070707070707FD, 8'hFF, 64'h07070707070707FD, 8'hFF};
        vecs[4] = '{3,  -1, 2, 64'h07070707FD030201, 8'hF8, 64'h07070707FD030201, 8'hF8};
        vecs[5] = '{15, -1, 3, 64'h0807060504030201, 8'h00, 64'hFD0F0E0D0C0B0A09, 8'h80};
        vecs[6] = '{16, -1, 4, 64'h0807060504030201, 8'h00, 64'h07070707070707FD, 8'hFF};
        vecs[7] = '{10,  9, 3, 64'h0807060504030201, 8'h00, 64'h0707070707FDFE09, 8'hFE};

        rst = 1'b1;
        dv  = 1'b0;
        er  = 1'b0;
        rxd = 8'h00;

        // Reset state
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 8'h00);
        check_word("reset_state", x1_v, x1_d, x1_c, 1'b0, IDLE_W, 8'hFF);
        quiet(5);

        // Table-driven frames, checked on the frame-only instance
        for (int t = 0; t < 8; t++) begin
            fw_q.delete();
            send_frame(vecs[t].ndata, vecs[t].er_pos, 1'b0);
            check_int($sformatf("vec%0d_nwords", t), fw_q.size(), vecs[t].nwords);
            if (fw_q.size() >= 1)
                check_fw($sformatf("vec%0d_word0", t), fw_q[0], SOF_W, 8'h01);
            if (fw_q.size() >= 2) begin
                check_fw($sformatf("vec%0d_word1", t), fw_q[1], vecs[t].w_mid, vecs[t].c_mid);
                check_fw($sformatf("vec%0d_last", t), fw_q[fw_q.size()-1],
                         vecs[t].w_last, vecs[t].c_last);
            end
            quiet(12);
        end

        // Frame start three byte times after an idle wrap -> flush first
        seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 8'h00);
            if (x1_v) seen = 1;
        end
        check_int("idle_wrap_seen", seen, 1);
        quiet(3);
        fw_q.delete();
        send_frame(8, -1, 1'b1);
        check_int("flush_frame_nwords", fw_q.size(), 3);
        if (fw_q.size() == 3) begin
            check_fw("flush_frame_word0", fw_q[0], SOF_W, 8'h01);
            check_fw("flush_frame_word1", fw_q[1], 64'h0807060504030201, 8'h00);
            check_fw("flush_frame_word2", fw_q[2], 64'h07070707070707FD, 8'hFF);
        end
        quiet(12);

        // Reset after 12 frame bytes, released while the frame continues
        fw_q.delete();
        for (int i = 0; i < 12; i++)
            cyc(1'b0, 1'b1, 1'b0, (i < 7) ? 8'h55 : (i == 7) ? 8'hD5 : 8'(i - 7));
        n = 0;
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 8'h05);
            n += int'(x1_v);
        end
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 8'($urandom));
            n += int'(x1_v);
        end
        check_int("drop_no_words", n, 0);
        check_int("drop_frame_words", fw_q.size(), 1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 8'h00);
            if (x1_v && x1_d == IDLE_W) seen++;
        end
        check_int("idle_after_drop", int'(seen > 0), 1);

        // Idle words disabled: 200 quiet cycles with no strobe
        n = 0;
        for (int i = 0; i < 200; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 8'h00);
            n += int'(x0_v);
        end
        check_int("no_idle_words_when_disabled", n, 0);

        // Randomized frames, errors, stray gmii_er and resets, checked per cycle
        for (int f = 0; f < 40; f++) begin
            nd     = $urandom_range(0, 40);
            rst_at = ($urandom_range(0, 7) == 0) ? $urandom_range(1, nd + 7) : -1;
            for (int b = 0; b < 8 + nd; b++) begin
                if (b == rst_at) begin
                    cyc(1'b1, 1'b1, 1'b0, 8'h00);
                    cyc(1'b1, 1'b1, 1'b0, 8'h00);
                end
                cyc(1'b0, 1'b1,
                    (b >= 8) && ($urandom_range(0, 15) == 0),
                    (b < 7) ? 8'h55 : (b == 7) ? 8'hD5 : 8'($urandom));
            end
            n = $urandom_range(9, 30);
            for (int g = 0; g < n; g++)
                cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
